pc_stack: RTL and testbench
===========================

# pc_stack

Parametrised program counter for the Hack SoC CPU core, successor to the single-register PC. It adds a configurable word width and reset vector, PC-relative branching, and a hardware return-address stack of configurable depth with call/return operations and sticky overflow/underflow flags. It sits between the instruction decoder (which drives the control strobes) and the instruction-memory address bus (driven by `out`).

## Interface

Parameters:
- D_WIDTH, 16, word size of PC, `in`, and stack entries.
- DEPTH, 8, number of return-address stack entries (≥2, power of two not required).
- RESET_VECTOR, 0, PC value after reset (D_WIDTH bits).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset_n  input  1  synchronous active-low reset; sampled on the rising edge of clk.
- in  input  D_WIDTH  jump target (load/call) or two's-complement offset (rel).
- load  input  1  absolute jump: PC <= in.
- rel  input  1  relative jump: PC <= out + in.
- inc  input  1  advance: PC <= out + 1.
- call  input  1  push out+1, then PC <= in.
- ret  input  1  pop: PC <= top of stack.
- clear_err  input  1  clears the sticky overflow/underflow flags.
- out  output  D_WIDTH  current PC (registered).
- top  output  D_WIDTH  current top-of-stack entry. Zero when empty.
- depth  output  $clog2(DEPTH+1)  number of valid stack entries.
- full  output  1  depth == DEPTH.
- empty  output  1  depth == 0.
- overflow  output  1  sticky; set by call when full.
- underflow  output  1  sticky; set by ret when empty.

## Operation

- Every state element (PC, stack storage, stack pointer, flags) updates only on the rising edge of clk.
- Per-edge priority is reset_n low > call > ret > load > rel > inc > hold. Exactly one action is taken per edge, and lower-priority strobes that are asserted at the same time are ignored.
- Reset (reset_n == 0): out = RESET_VECTOR, depth = 0, overflow = 0, underflow = 0. Stack contents are don't-care; `top` reads 0. Reset overrides every other input, including mid-call or mid-ret.
- call:
  - If not full: write out+1 (mod 2^D_WIDTH) at the stack pointer, increment depth, PC <= in.
  - If full: push is discarded, depth unchanged, existing entries unchanged, overflow <= 1, PC <= in (the jump still happens).
- ret:
  - If not empty: PC <= top, decrement depth.
  - If empty: PC holds, underflow <= 1.
- load: PC <= in.
- rel: PC <= (out + in) mod 2^D_WIDTH. `in` is treated as signed, so backward branches wrap naturally.
- inc: PC <= (out + 1) mod 2^D_WIDTH. All-ones wraps to 0.
- No strobe asserted: PC holds.
- clear_err:
  - Clears both flags on the edge.
  - If a call-when-full or ret-when-empty occurs on the same edge, the set wins: that flag reads 1.
  - clear_err has no effect on PC or stack.
- Return address width equals D_WIDTH. No truncation or sign extension anywhere.
- `top` = entry[depth-1] when depth > 0, else 0. `full`, `empty` and `top` are combinational decodes of registered state, with no extra latency.

## Timing

- Latency is 1 cycle: a strobe sampled at edge N is reflected on out/depth/top/flags after edge N and stable for the rest of cycle N+1.
- Back-to-back calls and rets are legal every cycle. A ret on the edge immediately after a call returns the address just pushed.
- A return address pushed at edge N is visible on `top` after edge N.
- reset_n must be held low for at least one rising edge. The first non-reset edge applies normal priority to whatever strobes are present.
- No combinational path from any input to any output.

## Test plan

- **Reset / RESET_VECTOR:** RESET_VECTOR=16'h0100, reset_n low 2 cycles with load=1, in=16'hFFFF -> out=16'h0100, depth=0, empty=1, flags=0.
- **inc wrap and hold:**
  - out=16'hFFFE, inc for 2 edges -> out=16'hFFFF, then 16'h0000.
  - No strobes for 3 edges -> out stays 16'h0000.
- **rel both directions:**
  - out=16'h0010, rel with in=16'hFFFC -> out=16'h000C.
  - Then rel with in=16'h0004 -> out=16'h0010.
  - load+rel+inc together with in=16'h0200 -> out=16'h0200 (load wins).
- **Nested call/ret:**
  - From out=16'h0005: call in=16'h0100, then call in=16'h0200 -> depth=2, top=16'h0101.
  - ret -> out=16'h0101, then ret -> out=16'h0006, depth=0.
- **Overflow (DEPTH=8):**
  - 9 consecutive calls -> depth=8, full=1, overflow=1 after the 9th, out = 9th target.
  - 8 rets return the first 8 pushed addresses in LIFO order.
  - clear_err -> overflow=0.
- **Underflow and simultaneous events:**
  - ret when empty -> out unchanged, underflow=1.
  - ret+clear_err when empty -> underflow stays 1.
  - call+ret together with depth=1 -> call wins, depth=2.
  - reset_n low together with call -> depth=0, out=RESET_VECTOR.

Source files
------------

// File: rtl/pc_stack.sv
// Hack SoC program counter with PC-relative branching and a return-address stack.
// One action per edge, priority: reset > call > ret > load > rel > inc > hold.
module pc_stack #(
    parameter int                 D_WIDTH      = 16,
    parameter int                 DEPTH        = 8,
    parameter logic [D_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [D_WIDTH-1:0]         in,
    input  logic                       load,
    input  logic                       rel,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       clear_err,
    output logic [D_WIDTH-1:0]         out,
    output logic [D_WIDTH-1:0]         top,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int              DW        = $clog2(DEPTH + 1);
    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0]   DEPTH_MAX = DW'(DEPTH);

    logic [D_WIDTH-1:0] pc_q, pc_d;
    logic [DW-1:0]      depth_q, depth_d;
    logic [D_WIDTH-1:0] stack_q [DEPTH];
    logic [D_WIDTH-1:0] stack_d [DEPTH];
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [D_WIDTH-1:0] top_val;
    logic               is_full, is_empty;

    assign is_full  = (depth_q == DEPTH_MAX);
    assign is_empty = (depth_q == '0);

    always_comb begin
        top_val = '0;
        if (!is_empty) begin
            top_val = stack_q[AW'(depth_q - DW'(1))];
        end
    end

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        stack_d = stack_q;
        // A flag set on the same edge as clear_err must win, so clear first.
        ovf_d   = ovf_q & ~clear_err;
        unf_d   = unf_q & ~clear_err;

        if (call) begin
            if (!is_full) begin
                stack_d[AW'(depth_q)] = pc_q + D_WIDTH'(1);
                depth_d               = depth_q + DW'(1);
            end else begin
                ovf_d = 1'b1;
            end
            pc_d = in;
        end else if (ret) begin
            if (!is_empty) begin
                pc_d    = top_val;
                depth_d = depth_q - DW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else if (load) begin
            pc_d = in;
        end else if (rel) begin
            pc_d = pc_q + in;
        end else if (inc) begin
            pc_d = pc_q + D_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q    <= RESET_VECTOR;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage is not reset; entries above depth are never observed.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            stack_q <= stack_d;
        end
    end

    assign out       = pc_q;
    assign top       = top_val;
    assign depth     = depth_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Scoreboard bench for pc_stack: the driver queues hand-computed expectations,
// a monitor pops one per cycle and compares against the registered outputs.
module tb_pc_stack;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in;
    logic        load, rel, inc, call, ret, clear_err;
    logic [15:0] out, top;
    logic [3:0]  depth;
    logic        full, empty, overflow, underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic [3:0]  depth;
        logic [15:0] top;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q [$];

    pc_stack #(
        .D_WIDTH     (16),
        .DEPTH       (8),
        .RESET_VECTOR(16'h0100)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in),
        .load     (load),
        .rel      (rel),
        .inc      (inc),
        .call     (call),
        .ret      (ret),
        .clear_err(clear_err),
        .out      (out),
        .top      (top),
        .depth    (depth),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; the expectation is queued just after
    // the rising edge that applies them and checked on the following falling edge.
    task automatic step(input string nm, input bit chk,
                        input logic rn, input logic ld, input logic rl, input logic ic,
                        input logic cl, input logic rt, input logic ce,
                        input logic [15:0] din,
                        input logic [15:0] eo, input logic [3:0] ed, input logic [15:0] et,
                        input logic eov, input logic eun);
        exp_t e;
        @(negedge clk);
        reset_n = rn; load = ld; rel = rl; inc = ic;
        call = cl; ret = rt; clear_err = ce; in = din;
        @(posedge clk);
        #1;
        if (chk) begin
            e.name  = nm;
            e.out   = eo;
            e.depth = ed;
            e.top   = et;
            e.full  = (ed == 4'd8);
            e.empty = (ed == 4'd0);
            e.ovf   = eov;
            e.unf   = eun;
            exp_q.push_back(e);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({out, depth, top, full, empty, overflow, underflow} !==
                    {e.out, e.depth, e.top, e.full, e.empty, e.ovf, e.unf}) begin
                    errors++;
                    $display("FAIL %s: got out=%h depth=%0d top=%h full=%b empty=%b ovf=%b unf=%b, want out=%h depth=%0d top=%h full=%b empty=%b ovf=%b unf=%b",
                             e.name, out, depth, top, full, empty, overflow, underflow,
                             e.out, e.depth, e.top, e.full, e.empty, e.ovf, e.unf);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $fatal(1);
    end

    initial begin : driver
        logic [15:0] ent [8];
        reset_n = 1'b0; load = 1'b0; rel = 1'b0; inc = 1'b0;
        call = 1'b0; ret = 1'b0; clear_err = 1'b0; in = 16'h0000;

        //   name             chk rn ld rl ic cl rt ce  in        out       d  top      ov unf
        step("reset_1",        1, 0, 1, 0, 0, 0, 0, 0, 16'hFFFF, 16'h0100, 0, 16'h0000, 0, 0);
        step("reset_2",        1, 0, 1, 0, 0, 0, 0, 0, 16'hFFFF, 16'h0100, 0, 16'h0000, 0, 0);
        step("load_fffe",      1, 1, 1, 0, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE, 0, 16'h0000, 0, 0);
        step("inc_ffff",       1, 1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 16'h0000, 0, 0);
        step("inc_wrap",       1, 1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0);
        for (int i = 0; i < 3; i++)
            step("hold",       1, 1, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 0, 16'h0000, 0, 0);
        step("load_0010",      1, 1, 1, 0, 0, 0, 0, 0, 16'h0010, 16'h0010, 0, 16'h0000, 0, 0);
        step("rel_back",       1, 1, 0, 1, 0, 0, 0, 0, 16'hFFFC, 16'h000C, 0, 16'h0000, 0, 0);
        step("rel_fwd",        1, 1, 0, 1, 0, 0, 0, 0, 16'h0004, 16'h0010, 0, 16'h0000, 0, 0);
        step("load_wins",      1, 1, 1, 1, 1, 0, 0, 0, 16'h0200, 16'h0200, 0, 16'h0000, 0, 0);

        step("load_0005",      1, 1, 1, 0, 0, 0, 0, 0, 16'h0005, 16'h0005, 0, 16'h0000, 0, 0);
        step("call_0100",      1, 1, 0, 0, 0, 1, 0, 0, 16'h0100, 16'h0100, 1, 16'h0006, 0, 0);
        step("call_0200",      1, 1, 0, 0, 0, 1, 0, 0, 16'h0200, 16'h0200, 2, 16'h0101, 0, 0);
        step("ret_0101",       1, 1, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0101, 1, 16'h0006, 0, 0);
        step("ret_0006",       1, 1, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0006, 0, 16'h0000, 0, 0);

        // Nine calls from out=0006 to targets 1000,1010,...,1080.
        ent[0] = 16'h0007;
        for (int j = 1; j < 8; j++) ent[j] = 16'h1000 + 16'(j - 1) * 16'h0010 + 16'h0001;
        for (int i = 0; i < 8; i++)
            step("call_fill",  1, 1, 0, 0, 0, 1, 0, 0, 16'h1000 + 16'(i) * 16'h0010,
                 16'h1000 + 16'(i) * 16'h0010, 4'(i + 1), ent[i], 0, 0);
        step("call_ovf",       1, 1, 0, 0, 0, 1, 0, 0, 16'h1080, 16'h1080, 8, 16'h1061, 1, 0);
        for (int k = 0; k < 8; k++)
            step("ret_lifo",   1, 1, 0, 0, 0, 0, 1, 0, 16'h0000, ent[7 - k], 4'(7 - k),
                 (k < 7) ? ent[6 - k] : 16'h0000, 1, 0);
        step("clear_ovf",      1, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0007, 0, 16'h0000, 0, 0);

        step("ret_empty",      1, 1, 0, 0, 0, 0, 1, 0, 16'h0000, 16'h0007, 0, 16'h0000, 0, 1);
        step("ret_clr_set",    1, 1, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0007, 0, 16'h0000, 0, 1);
        step("clear_unf",      1, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0007, 0, 16'h0000, 0, 0);
        step("call_0300",      1, 1, 0, 0, 0, 1, 0, 0, 16'h0300, 16'h0300, 1, 16'h0008, 0, 0);
        step("call_ret_both",  1, 1, 0, 0, 0, 1, 1, 0, 16'h0400, 16'h0400, 2, 16'h0301, 0, 0);
        step("reset_call",     1, 0, 0, 0, 0, 1, 0, 0, 16'h0500, 16'h0100, 0, 16'h0000, 0, 0);
        step("post_reset_inc", 1, 1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0101, 0, 16'h0000, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
